// File: rtl/mem_req_arbiter_pkg.sv
// Shared definitions for the three-requester memory arbiter.
// Holds the FSM encoding, requester indices, field widths and one-hot helpers.
package mem_req_arbiter_pkg;

  localparam int N_REQ  = 3;
  localparam int LEN_WD = 3;
  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int SW     = 4;

  localparam logic [1:0] IDX_IC = 2'd0;
  localparam logic [1:0] IDX_DC = 2'd1;
  localparam logic [1:0] IDX_UC = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_RDATA = 2'd2,
    ST_WRESP = 2'd3
  } state_t;

  function automatic logic [2:0] idx2oh(input logic [1:0] idx);
    case (idx)
      IDX_IC:  idx2oh = 3'b001;
      IDX_DC:  idx2oh = 3'b010;
      IDX_UC:  idx2oh = 3'b100;
      default: idx2oh = 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] oh2idx(input logic [2:0] oh);
    case (oh)
      3'b010:  oh2idx = IDX_DC;
      3'b100:  oh2idx = IDX_UC;
      default: oh2idx = IDX_IC;
    endcase
  endfunction

endpackage

// File: rtl/mem_req_arbiter_rr.sv
// Round-robin pick among three requesters; the search starts one past the
// most recently served index. Purely combinational.
module rr_pick3 (
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [2:0] gnt
);

  // priority rotation keyed on the last served requester
  always_comb begin
    gnt = 3'b000;
    case (last)
      2'd0: begin
        if (req[1])      gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
        else             gnt = 3'b000;
      end
      2'd1: begin
        if (req[2])      gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
        else             gnt = 3'b000;
      end
      default: begin
        if (req[0])      gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
        else             gnt = 3'b000;
      end
    endcase
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Arbitrates icache/dcache/uncache requests onto one burst bus. The winner's
// command is latched in IDLE and held until its read burst or write response ends.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int N_REQ  = mem_req_arbiter_pkg::N_REQ,
  parameter int LEN_WD = mem_req_arbiter_pkg::LEN_WD
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_we,
  input  logic [N_REQ*AW-1:0]     req_addr,
  input  logic [N_REQ*LEN_WD-1:0] req_len,
  input  logic [N_REQ*SW-1:0]     req_wstrb,
  input  logic [N_REQ*DW-1:0]     req_wdata,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        rsp_rvalid,
  output logic [DW-1:0]           rsp_rdata,
  output logic                    rsp_last,
  output logic [N_REQ-1:0]        rsp_done,
  output logic                    busy,
  output logic                    bus_req,
  output logic                    bus_we,
  output logic [AW-1:0]           bus_addr,
  output logic [LEN_WD-1:0]       bus_len,
  output logic [SW-1:0]           bus_wstrb,
  output logic [DW-1:0]           bus_wdata,
  input  logic                    bus_addr_ok,
  input  logic                    bus_rvalid,
  input  logic                    bus_rlast,
  input  logic                    bus_wr_ok,
  input  logic [DW-1:0]           bus_rdata
);

  state_t              state_r, next_state_s;
  logic [1:0]          idx_r, last_idx_r, pick_idx_s;
  logic [2:0]          pick_oh_s;
  logic                load_s, done_s;
  logic                we_r, sel_we_s;
  logic [AW-1:0]       addr_r, sel_addr_s;
  logic [LEN_WD-1:0]   len_r, sel_len_s;
  logic [SW-1:0]       wstrb_r, sel_wstrb_s;
  logic [DW-1:0]       wdata_r, sel_wdata_s;

  rr_pick3 u_pick (
    .req  (req_valid),
    .last (last_idx_r),
    .gnt  (pick_oh_s)
  );

  assign pick_idx_s = oh2idx(pick_oh_s);

  // extract the winning requester's command fields from the packed buses
  always_comb begin
    sel_we_s    = req_we[0];
    sel_addr_s  = req_addr[AW-1:0];
    sel_len_s   = req_len[LEN_WD-1:0];
    sel_wstrb_s = req_wstrb[SW-1:0];
    sel_wdata_s = req_wdata[DW-1:0];
    case (pick_idx_s)
      IDX_DC: begin
        sel_we_s    = req_we[1];
        sel_addr_s  = req_addr[2*AW-1:AW];
        sel_len_s   = req_len[2*LEN_WD-1:LEN_WD];
        sel_wstrb_s = req_wstrb[2*SW-1:SW];
        sel_wdata_s = req_wdata[2*DW-1:DW];
      end
      IDX_UC: begin
        sel_we_s    = req_we[2];
        sel_addr_s  = req_addr[3*AW-1:2*AW];
        sel_len_s   = req_len[3*LEN_WD-1:2*LEN_WD];
        sel_wstrb_s = req_wstrb[3*SW-1:2*SW];
        sel_wdata_s = req_wdata[3*DW-1:2*DW];
      end
      default: begin
        sel_we_s    = req_we[0];
        sel_addr_s  = req_addr[AW-1:0];
        sel_len_s   = req_len[LEN_WD-1:0];
        sel_wstrb_s = req_wstrb[SW-1:0];
        sel_wdata_s = req_wdata[DW-1:0];
      end
    endcase
  end

  // next state and the same-cycle response strobes; bus inputs outside
  // their owning state fall through untouched
  always_comb begin
    next_state_s = state_r;
    load_s       = 1'b0;
    done_s       = 1'b0;
    gnt          = 3'b000;
    rsp_rvalid   = 3'b000;
    rsp_rdata    = 32'h0000_0000;
    rsp_last     = 1'b0;
    rsp_done     = 3'b000;
    case (state_r)
      ST_IDLE: begin
        if (|req_valid) begin
          load_s       = 1'b1;
          next_state_s = ST_ADDR;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (bus_addr_ok) begin
          gnt          = idx2oh(idx_r);
          next_state_s = we_r ? ST_WRESP : ST_RDATA;
        end else begin
          next_state_s = ST_ADDR;
        end
      end
      ST_RDATA: begin
        if (bus_rvalid) begin
          rsp_rvalid = idx2oh(idx_r);
          rsp_rdata  = bus_rdata;
          rsp_last   = bus_rlast;
          if (bus_rlast) begin
            rsp_done     = idx2oh(idx_r);
            done_s       = 1'b1;
            next_state_s = ST_IDLE;
          end else begin
            next_state_s = ST_RDATA;
          end
        end else begin
          next_state_s = ST_RDATA;
        end
      end
      ST_WRESP: begin
        if (bus_wr_ok) begin
          rsp_done     = idx2oh(idx_r);
          done_s       = 1'b1;
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_WRESP;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // state, latched command and round-robin history
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      last_idx_r <= IDX_UC;
      idx_r      <= 2'd0;
      we_r       <= 1'b0;
      addr_r     <= 32'h0000_0000;
      len_r      <= '0;
      wstrb_r    <= 4'h0;
      wdata_r    <= 32'h0000_0000;
    end else begin
      state_r <= next_state_s;
      if (load_s) begin
        idx_r   <= pick_idx_s;
        we_r    <= sel_we_s;
        addr_r  <= sel_addr_s;
        len_r   <= sel_len_s;
        wstrb_r <= sel_wstrb_s;
        wdata_r <= sel_wdata_s;
      end
      if (done_s) begin
        last_idx_r <= idx_r;
      end
    end
  end

  // bus command comes straight from flops so it cannot glitch during ADDR
  assign busy      = (state_r != ST_IDLE);
  assign bus_req   = (state_r == ST_ADDR);
  assign bus_we    = we_r;
  assign bus_addr  = addr_r;
  assign bus_len   = we_r ? '0 : len_r;
  assign bus_wstrb = wstrb_r;
  assign bus_wdata = wdata_r;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: round-robin reads, a dcache write,
// address back-pressure, mid-burst reset, fairness and single-beat reads.
module tb_mem_req_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req_valid, req_we;
  logic [95:0] req_addr;
  logic [8:0]  req_len;
  logic [11:0] req_wstrb;
  logic [95:0] req_wdata;
  logic [2:0]  gnt, rsp_rvalid, rsp_done;
  logic [31:0] rsp_rdata;
  logic        rsp_last, busy;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [2:0]  bus_len;
  logic [3:0]  bus_wstrb;
  logic        bus_addr_ok, bus_rvalid, bus_rlast, bus_wr_ok;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_req_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_len     (req_len),
    .req_wstrb   (req_wstrb),
    .req_wdata   (req_wdata),
    .gnt         (gnt),
    .rsp_rvalid  (rsp_rvalid),
    .rsp_rdata   (rsp_rdata),
    .rsp_last    (rsp_last),
    .rsp_done    (rsp_done),
    .busy        (busy),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_len     (bus_len),
    .bus_wstrb   (bus_wstrb),
    .bus_wdata   (bus_wdata),
    .bus_addr_ok (bus_addr_ok),
    .bus_rvalid  (bus_rvalid),
    .bus_rlast   (bus_rlast),
    .bus_wr_ok   (bus_wr_ok),
    .bus_rdata   (bus_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Caller sets req_valid while the FSM is idle; this drives one read to completion.
  task automatic run_read(input int who, input logic [31:0] a, input int beats,
                          input logic keep, input logic [2:0] add_mid);
    logic [2:0]  oh;
    logic [31:0] d;
    oh = 3'b001 << who;
    cyc();
    #1;
    chk("rd_bus_req",  32'(bus_req), 32'd1);
    chk("rd_bus_addr", bus_addr, a);
    chk("rd_bus_len",  32'(bus_len), 32'(beats - 1));
    chk("rd_bus_we",   32'(bus_we), 32'd0);
    chk("rd_gnt_wait", 32'(gnt), 32'd0);
    bus_addr_ok = 1'b1;
    #1 chk("rd_gnt", 32'(gnt), 32'(oh));
    cyc();
    bus_addr_ok = 1'b0;
    if (!keep) req_valid = req_valid & ~oh;
    for (int b = 0; b < beats; b++) begin
      if (b == 0) req_valid = req_valid | add_mid;
      d = 32'hD000_0000 + 32'(who * 16 + b);
      bus_rvalid = 1'b1;
      bus_rdata  = d;
      bus_rlast  = (b == beats - 1);
      #1;
      chk("rd_rvalid", 32'(rsp_rvalid), 32'(oh));
      chk("rd_rdata",  rsp_rdata, d);
      chk("rd_last",   32'(rsp_last), (b == beats - 1) ? 32'd1 : 32'd0);
      chk("rd_done",   32'(rsp_done), (b == beats - 1) ? 32'(oh) : 32'd0);
      chk("rd_busy",   32'(busy), 32'd1);
      cyc();
    end
    bus_rvalid = 1'b0;
    bus_rlast  = 1'b0;
    bus_rdata  = 32'h0;
    #1;
    chk("rd_end_busy", 32'(busy), 32'd0);
    chk("rd_gap_req",  32'(bus_req), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 3'b000; req_we = 3'b000; req_addr = 96'h0; req_len = 9'h0;
    req_wstrb = 12'h0; req_wdata = 96'h0;
    bus_addr_ok = 1'b0; bus_rvalid = 1'b0; bus_rlast = 1'b0; bus_wr_ok = 1'b0;
    bus_rdata = 32'h0;
    #1;
    chk("rst_busy",   32'(busy), 32'd0);
    chk("rst_bus",    {27'd0, bus_req, bus_we, bus_len}, 32'd0);
    chk("rst_addr",   bus_addr, 32'd0);
    chk("rst_rsp",    {23'd0, gnt, rsp_rvalid, rsp_done}, 32'd0);
    cyc(); cyc();
    reset = 1'b0;

    // three reads pending together: ic, dc, uc in turn
    req_addr  = {32'h3000_0300, 32'h2000_0200, 32'h1000_0100};
    req_len   = {3'd3, 3'd3, 3'd3};
    req_valid = 3'b111;
    run_read(0, 32'h1000_0100, 4, 1'b0, 3'b000);
    run_read(1, 32'h2000_0200, 4, 1'b0, 3'b000);
    run_read(2, 32'h3000_0300, 4, 1'b0, 3'b000);

    // dcache write with back-pressure, stray responses and late field changes
    req_we    = 3'b010;
    req_addr  = {32'h0, 32'h1C00_0010, 32'h0};
    req_wstrb = {4'h0, 4'b0011, 4'h0};
    req_wdata = {32'h0, 32'h1234_5678, 32'h0};
    req_len   = {3'd0, 3'd5, 3'd0};
    req_valid = 3'b010;
    cyc();
    #1;
    chk("wr_bus_req",   32'(bus_req), 32'd1);
    chk("wr_bus_we",    32'(bus_we), 32'd1);
    chk("wr_bus_len",   32'(bus_len), 32'd0);
    chk("wr_bus_addr",  bus_addr, 32'h1C00_0010);
    chk("wr_bus_wstrb", 32'(bus_wstrb), 32'h3);
    chk("wr_bus_wdata", bus_wdata, 32'h1234_5678);
    req_addr  = {32'h0, 32'hDEAD_BEEF, 32'h0};
    req_wdata = {32'h0, 32'hCAFE_F00D, 32'h0};
    bus_wr_ok = 1'b1;
    #1;
    chk("wr_stray_ok_done", 32'(rsp_done), 32'd0);
    chk("wr_stray_ok_gnt",  32'(gnt), 32'd0);
    cyc();
    bus_wr_ok = 1'b0;
    #1;
    chk("wr_still_addr", 32'(bus_req), 32'd1);
    chk("wr_hold_addr",  bus_addr, 32'h1C00_0010);
    chk("wr_hold_wdata", bus_wdata, 32'h1234_5678);
    bus_addr_ok = 1'b1;
    #1 chk("wr_gnt", 32'(gnt), 32'b010);
    cyc();
    bus_addr_ok = 1'b0;
    req_valid = 3'b000;
    bus_rvalid = 1'b1; bus_rlast = 1'b1;
    #1;
    chk("wr_stray_rvalid", 32'(rsp_rvalid), 32'd0);
    chk("wr_stray_done",   32'(rsp_done), 32'd0);
    chk("wr_wresp_busy",   32'(busy), 32'd1);
    cyc();
    bus_rvalid = 1'b0; bus_rlast = 1'b0;
    bus_wr_ok = 1'b1;
    #1 chk("wr_done", 32'(rsp_done), 32'b010);
    cyc();
    bus_wr_ok = 1'b0;
    req_we = 3'b000;
    #1;
    chk("wr_end_busy", 32'(busy), 32'd0);

    // icache read with bus_addr_ok held low for five cycles
    req_addr  = {32'h0, 32'h0, 32'h0000_8800};
    req_len   = 9'h0;
    req_valid = 3'b001;
    cyc();
    for (int k = 0; k < 5; k++) begin
      req_addr = {32'h0, 32'h0, 32'h0000_8800 ^ 32'(k + 1)};
      #1;
      chk("bp_req",  32'(bus_req), 32'd1);
      chk("bp_addr", bus_addr, 32'h0000_8800);
      chk("bp_gnt",  32'(gnt), 32'd0);
      cyc();
    end
    bus_addr_ok = 1'b1; bus_rvalid = 1'b1; bus_rlast = 1'b1; bus_rdata = 32'h1111_2222;
    #1;
    chk("bp_gnt_ok",    32'(gnt), 32'b001);
    chk("bp_beat_ign",  32'(rsp_rvalid), 32'd0);
    chk("bp_done_ign",  32'(rsp_done), 32'd0);
    cyc();
    bus_addr_ok = 1'b0;
    req_valid = 3'b000;
    bus_rdata = 32'h3333_4444;
    #1;
    chk("bp_rvalid", 32'(rsp_rvalid), 32'b001);
    chk("bp_rdata",  rsp_rdata, 32'h3333_4444);
    chk("bp_done",   32'(rsp_done), 32'b001);
    cyc();
    bus_rvalid = 1'b0; bus_rlast = 1'b0;
    #1 chk("bp_end_busy", 32'(busy), 32'd0);

    // reset in the middle of a four-beat read
    req_addr  = {32'h0, 32'h0, 32'h0000_4000};
    req_len   = {3'd0, 3'd0, 3'd3};
    req_valid = 3'b001;
    cyc();
    bus_addr_ok = 1'b1;
    #1 chk("mr_gnt", 32'(gnt), 32'b001);
    cyc();
    bus_addr_ok = 1'b0;
    req_valid = 3'b000;
    for (int b = 0; b < 2; b++) begin
      bus_rvalid = 1'b1; bus_rdata = 32'(b + 7);
      #1 chk("mr_beat", 32'(rsp_rvalid), 32'b001);
      cyc();
    end
    bus_rvalid = 1'b1; bus_rdata = 32'h99;
    reset = 1'b1;
    #1;
    chk("mr_rvalid", 32'(rsp_rvalid), 32'd0);
    chk("mr_rdata",  rsp_rdata, 32'd0);
    chk("mr_done",   32'(rsp_done), 32'd0);
    chk("mr_busy",   32'(busy), 32'd0);
    chk("mr_bus",    {27'd0, bus_req, bus_we, bus_len}, 32'd0);
    chk("mr_addr",   bus_addr, 32'd0);
    cyc();
    reset = 1'b0;
    bus_rlast = 1'b1;
    #1;
    chk("mr_late_rvalid", 32'(rsp_rvalid), 32'd0);
    chk("mr_late_done",   32'(rsp_done), 32'd0);
    cyc();
    bus_rvalid = 1'b0; bus_rlast = 1'b0;

    // icache held continuously, dcache joins mid-burst and goes next
    req_addr  = {32'h0, 32'h2000_0040, 32'h1000_0040};
    req_len   = {3'd0, 3'd0, 3'd1};
    req_valid = 3'b001;
    run_read(0, 32'h1000_0040, 2, 1'b1, 3'b010);
    run_read(1, 32'h2000_0040, 1, 1'b0, 3'b000);
    run_read(0, 32'h1000_0040, 2, 1'b0, 3'b000);

    // single-beat uncache read
    req_addr  = {32'h3FFF_FFF0, 32'h0, 32'h0};
    req_len   = 9'h0;
    req_valid = 3'b100;
    run_read(2, 32'h3FFF_FFF0, 1, 1'b0, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_req_arbiter.md
MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 Parameter N_REQ, default 3, is the requester count: index 0 icache, 1 dcache, 2 uncache; the value is fixed, not generic.
REQ-002 Parameter LEN_WD, default 3, is the burst-length field width; beats = len+1, 1..8.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  3  per-requester request, held until that requester's gnt bit.
REQ-006 req_we  input  3  per-requester write flag (bit 0 tied 0 by the icache).
REQ-007 req_addr  input  96  packed {uc,dc,ic} 32-bit addresses.
REQ-008 req_len  input  9  packed {uc,dc,ic} LEN_WD-bit burst lengths; reads only.
REQ-009 req_wstrb  input  12  packed {uc,dc,ic} byte strobes.
REQ-010 req_wdata  input  96  packed {uc,dc,ic} write data.
REQ-011 gnt  output  3  one-hot, one-cycle pulse when the bus accepts the winner's address.
REQ-012 rsp_rvalid  output  3  one-hot read-beat strobe to the owning requester.
REQ-013 rsp_rdata  output  32  shared read data.
REQ-014 rsp_last  output  1  last read beat.
REQ-015 rsp_done  output  3  one-hot, one-cycle transaction-complete pulse.
REQ-016 busy  output  1  high when the FSM is not in IDLE.
REQ-017 bus_req, bus_we  output  1 each; bus_addr  output  32; bus_len  output  3; bus_wstrb  output  4; bus_wdata  output  32: registered bus command.
REQ-018 bus_addr_ok, bus_rvalid, bus_rlast, bus_wr_ok  input  1 each; bus_rdata  input  32: bus responses.

Function
REQ-019 The FSM SHALL have states IDLE, ADDR, RDATA and WRESP.
REQ-020 IDLE behaviour:
- When any req_valid bit is set, the arbiter SHALL select a winner round-robin, searching from (last_idx+1) mod 3.
- It SHALL latch idx, we, addr, len, wstrb and wdata, then move to ADDR.
REQ-021 ADDR behaviour:
- bus_req=1 and bus_* SHALL carry the latched fields.
- bus_len SHALL be 0 when we=1.
- When bus_addr_ok=1, gnt[idx] SHALL pulse in that same cycle and the FSM SHALL move to WRESP if we=1, else RDATA.
REQ-022 RDATA behaviour: each bus_rvalid SHALL combinationally drive rsp_rvalid[idx]=1, rsp_rdata=bus_rdata and rsp_last=bus_rlast.
REQ-023 RDATA completion: on bus_rvalid&bus_rlast, rsp_done[idx] SHALL pulse, last_idx<=idx, and the FSM SHALL return to IDLE.
REQ-024 WRESP behaviour: on bus_wr_ok, rsp_done[idx] SHALL pulse, last_idx<=idx, and the FSM SHALL return to IDLE.
REQ-025 Latency SHALL be:
- bus_req rises at the earliest one cycle after req_valid is sampled in IDLE.
- At least one bus_req-low cycle separates consecutive transactions.
REQ-026 Latched fields SHALL be used through completion; a requester changing req_* after latch has no effect on the transaction.
REQ-027 bus_req and bus_addr SHALL stay stable while bus_addr_ok is low, for any number of cycles.
REQ-028 Stray bus inputs SHALL be ignored:
- bus_rvalid outside RDATA.
- bus_wr_ok outside WRESP.
- bus_addr_ok outside ADDR.
REQ-029 A simultaneous bus_addr_ok and bus_rvalid in ADDR SHALL accept the address only; the beat is ignored.
REQ-030 When all three requests are pending continuously, each requester SHALL be granted within 3 transactions.

Reset
REQ-031 Reset values, applied immediately when reset asserts:
- state=IDLE, last_idx=2, so icache has first priority.
- All outputs 0.
- Latched fields 0.
REQ-032 Reset mid-transaction SHALL abort without issuing rsp_done; bus beats arriving afterwards SHALL be ignored.

Structure
REQ-033 FSM state encodings, requester indices (IC=0, DC=1, UC=2) and LEN_WD SHALL reside in the shared core package or defines file.
REQ-034 The round-robin selector SHALL be one sub-module, rr_pick3: inputs req[2:0] and last[1:0], output one-hot gnt[2:0], purely combinational.

Verification
REQ-035 The bench SHALL cover this scenario: after reset, req_valid=3'b111 with all reads, len=3 → grant order ic, dc, uc; each gets 4 rsp_rvalid beats; rsp_done coincides with bus_rlast; bus_req is low ≥1 cycle between transactions.
REQ-036 The bench SHALL cover this scenario: dc write addr=0x1C00_0010, wstrb=4'b0011, wdata=0x1234_5678 → bus_we=1, bus_len=0, gnt=3'b010 on bus_addr_ok, rsp_done=3'b010 the cycle bus_wr_ok=1.
REQ-037 The bench SHALL cover this scenario: ic read with bus_addr_ok held 0 for 5 cycles → bus_req/bus_addr stable throughout, no gnt until bus_addr_ok=1.
REQ-038 The bench SHALL cover this scenario: reset asserted in RDATA after 2 of 4 beats → all outputs 0 and busy=0 in the same cycle; later bus_rvalid produces no rsp_rvalid.
REQ-039 The bench SHALL cover this scenario: ic req_valid held continuously with dc asserted mid-ic-burst → dc is granted next, before ic's second transaction.
REQ-040 The bench SHALL cover this scenario: uc read len=0 with bus_rvalid&bus_rlast one cycle after addr_ok → single beat, rsp_last=1, rsp_done=3'b100, busy falls the next cycle.
